// File: rtl/reset_sequencer_pkg.sv
// Shared types, default parameters and helpers for the staged reset sequencer.
package reset_seq_pkg;

  localparam int unsigned DEF_NUM_STAGES     = 4;
  localparam int unsigned DEF_HOLD_CYCLES    = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  localparam int unsigned DEF_CNT_W          = 16;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    WAIT  = 3'd1,
    GAP   = 3'd2,
    RUN   = 3'd3,
    FAULT = 3'd4
  } seqState_t;

  // Width of a stage index; never narrower than one bit.
  function automatic int unsigned stageIdxWidth(input int unsigned numStages);
    return (numStages <= 2) ? 1 : $clog2(numStages);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its environment.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
);
  localparam int unsigned IDX_W = stageIdxWidth(NUM_STAGES);

  logic                  iSoftReset;
  logic [NUM_STAGES-1:0] iStageReady;
  logic [NUM_STAGES-1:0] oStageReset;
  logic                  oAllReady;
  logic                  oFault;
  logic [IDX_W-1:0]      oFaultStage;

  modport master (
    output iSoftReset, iStageReady,
    input  oStageReset, oAllReady, oFault, oFaultStage
  );

  modport slave (
    input  iSoftReset, iStageReady,
    output oStageReset, oAllReady, oFault, oFaultStage
  );
endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared by async reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      meta    <= '0;
      syncOut <= '0;
    end else begin
      meta    <= asyncIn;
      syncOut <= meta;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all domains in reset, then releases them in
// index order once each reports ready, faulting on timeout or ready loss.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = DEF_NUM_STAGES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input logic              iClock,
  input logic              iReset,
  reset_sequencer_if.slave bus
);
  localparam int unsigned      IDX_W        = stageIdxWidth(NUM_STAGES);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

  logic [NUM_STAGES-1:0] rdy;
  seqState_t             state;
  logic [CNT_W-1:0]      counter;
  logic [IDX_W-1:0]      idx;
  logic [NUM_STAGES-1:0] stageReset;
  logic                  allReady;
  logic                  fault;
  logic [IDX_W-1:0]      faultStage;
  logic [IDX_W-1:0]      lowNotReady_c;
  logic [IDX_W-1:0]      nextIdx_c;

  sync_2ff #(.WIDTH(NUM_STAGES)) uReadySync (
    .iClock  (iClock),
    .iReset  (iReset),
    .asyncIn (bus.iStageReady),
    .syncOut (rdy)
  );

  // Lowest-numbered stage whose synchronised ready is low.
  always_comb begin
    lowNotReady_c = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (!rdy[i]) lowNotReady_c = IDX_W'(i);
    end
  end

  assign nextIdx_c = idx + IDX_W'(1);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state      <= HOLD;
      counter    <= '0;
      idx        <= '0;
      stageReset <= '1;
      allReady   <= 1'b0;
      fault      <= 1'b0;
      faultStage <= '0;
    end else if (bus.iSoftReset) begin
      state      <= HOLD;
      counter    <= '0;
      idx        <= '0;
      stageReset <= '1;
      allReady   <= 1'b0;
      fault      <= 1'b0;
      faultStage <= '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (counter == HOLD_LAST) begin
            stageReset[0] <= 1'b0;
            counter       <= '0;
            idx           <= '0;
            state         <= WAIT;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        // Ready wins over a timeout landing on the same cycle.
        WAIT: begin
          if (rdy[idx]) begin
            counter <= '0;
            if (idx == LAST_IDX) begin
              state    <= RUN;
              allReady <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else if (counter == TIMEOUT_LAST) begin
            state      <= FAULT;
            counter    <= '0;
            stageReset <= '1;
            allReady   <= 1'b0;
            fault      <= 1'b1;
            faultStage <= idx;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        GAP: begin
          if (counter == HOLD_LAST) begin
            idx                   <= nextIdx_c;
            stageReset[nextIdx_c] <= 1'b0;
            counter               <= '0;
            state                 <= WAIT;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        RUN: begin
          if (rdy != '1) begin
            state      <= FAULT;
            stageReset <= '1;
            allReady   <= 1'b0;
            fault      <= 1'b1;
            faultStage <= lowNotReady_c;
          end else begin
            allReady <= 1'b1;
          end
        end
        FAULT: begin
          stageReset <= '1;
          allReady   <= 1'b0;
          fault      <= 1'b1;
        end
        default: begin
          state      <= HOLD;
          counter    <= '0;
          idx        <= '0;
          stageReset <= '1;
          allReady   <= 1'b0;
          fault      <= 1'b0;
          faultStage <= '0;
        end
      endcase
    end
  end

  assign bus.oStageReset = stageReset;
  assign bus.oAllReady   = allReady;
  assign bus.oFault      = fault;
  assign bus.oFaultStage = faultStage;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: 3 stages, hold/gap 4, timeout 16.
module tb_reset_sequencer;

  logic iClock;
  logic iReset;

  reset_sequencer_if #(.NUM_STAGES(3)) bus ();

  reset_sequencer #(
    .NUM_STAGES     (3),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (16)
  ) dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus)
  );

  typedef struct {
    int         edgeNo;
    logic [2:0] stageReset;
    logic       allReady;
    logic       fault;
    logic [1:0] faultStage;
  } exp_t;

  exp_t  sbQ[$];
  int    checks   = 0;
  int    failures = 0;
  int    edgeCnt  = 0;
  string scen     = "init";

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expVal);
    checks++;
    if (got !== expVal) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expVal);
    end
  endtask

  task automatic pushExp(input int e, input logic [2:0] sr, input logic ar,
                         input logic f, input logic [1:0] fs);
    exp_t x;
    x.edgeNo = e; x.stageReset = sr; x.allReady = ar; x.fault = f; x.faultStage = fs;
    sbQ.push_back(x);
  endtask

  // Expected outputs for a full release with every stage already ready.
  task automatic pushRelease();
    pushExp(3,  3'b111, 1'b0, 1'b0, 2'd0);
    pushExp(4,  3'b110, 1'b0, 1'b0, 2'd0);
    pushExp(8,  3'b110, 1'b0, 1'b0, 2'd0);
    pushExp(9,  3'b100, 1'b0, 1'b0, 2'd0);
    pushExp(13, 3'b100, 1'b0, 1'b0, 2'd0);
    pushExp(14, 3'b000, 1'b0, 1'b0, 2'd0);
    pushExp(15, 3'b000, 1'b1, 1'b0, 2'd0);
    pushExp(16, 3'b000, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic runEdges(input int n);
    exp_t  e;
    string pre;
    for (int k = 0; k < n; k++) begin
      @(posedge iClock);
      #1;
      edgeCnt++;
      while (sbQ.size() > 0 && sbQ[0].edgeNo <= edgeCnt) begin
        e   = sbQ.pop_front();
        pre = $sformatf("%s e%0d", scen, e.edgeNo);
        checkVal({pre, " stageReset"}, 32'(bus.oStageReset), 32'(e.stageReset));
        checkVal({pre, " allReady"},   32'(bus.oAllReady),   32'(e.allReady));
        checkVal({pre, " fault"},      32'(bus.oFault),      32'(e.fault));
        checkVal({pre, " faultStage"}, 32'(bus.oFaultStage), 32'(e.faultStage));
      end
    end
  endtask

  task automatic drain();
    checkVal({scen, " sbDrain"}, 32'(sbQ.size()), 32'd0);
    sbQ.delete();
  endtask

  task automatic softPulse();
    bus.iSoftReset = 1'b1;
    @(posedge iClock);
    #1;
    checkVal({scen, " soft stageReset"}, 32'(bus.oStageReset), 32'h7);
    checkVal({scen, " soft allReady"},   32'(bus.oAllReady),   32'h0);
    checkVal({scen, " soft fault"},      32'(bus.oFault),      32'h0);
    checkVal({scen, " soft faultStage"}, 32'(bus.oFaultStage), 32'h0);
    bus.iSoftReset = 1'b0;
    edgeCnt = 0;
  endtask

  initial begin
    iReset          = 1'b1;
    bus.iSoftReset  = 1'b0;
    bus.iStageReady = 3'b111;
    #12;
    scen = "reset";
    checkVal("reset stageReset", 32'(bus.oStageReset), 32'h7);
    checkVal("reset allReady",   32'(bus.oAllReady),   32'h0);
    checkVal("reset fault",      32'(bus.oFault),      32'h0);
    checkVal("reset faultStage", 32'(bus.oFaultStage), 32'h0);

    // Normal release from power-on reset.
    scen = "release";
    @(negedge iClock);
    iReset  = 1'b0;
    edgeCnt = 0;
    pushRelease();
    runEdges(16);
    drain();

    // Stage 1 drops its ready while running.
    scen = "readyLoss";
    bus.iStageReady = 3'b101;
    edgeCnt = 0;
    pushExp(1, 3'b000, 1'b1, 1'b0, 2'd0);
    pushExp(2, 3'b000, 1'b1, 1'b0, 2'd0);
    pushExp(3, 3'b111, 1'b0, 1'b1, 2'd1);
    pushExp(5, 3'b111, 1'b0, 1'b1, 2'd1);
    runEdges(5);
    drain();

    // Fault is sticky until a soft reset, which then replays the release.
    scen = "softRestart";
    bus.iStageReady = 3'b111;
    edgeCnt = 0;
    pushExp(3, 3'b111, 1'b0, 1'b1, 2'd1);
    runEdges(3);
    drain();
    softPulse();
    pushRelease();
    runEdges(16);
    drain();

    // Stage 1 never becomes ready.
    scen = "timeout";
    bus.iStageReady = 3'b101;
    softPulse();
    pushExp(9,  3'b100, 1'b0, 1'b0, 2'd0);
    pushExp(24, 3'b100, 1'b0, 1'b0, 2'd0);
    pushExp(25, 3'b111, 1'b0, 1'b1, 2'd1);
    pushExp(28, 3'b111, 1'b0, 1'b1, 2'd1);
    runEdges(28);
    drain();

    // Stage 2 ready arrives on the very last timeout cycle.
    scen = "lastCycleReady";
    bus.iStageReady = 3'b011;
    softPulse();
    pushExp(14, 3'b000, 1'b0, 1'b0, 2'd0);
    pushExp(27, 3'b000, 1'b0, 1'b0, 2'd0);
    runEdges(27);
    bus.iStageReady = 3'b111;
    pushExp(29, 3'b000, 1'b0, 1'b0, 2'd0);
    pushExp(30, 3'b000, 1'b1, 1'b0, 2'd0);
    pushExp(32, 3'b000, 1'b1, 1'b0, 2'd0);
    runEdges(5);
    drain();

    // Asynchronous reset in the middle of a gap.
    scen = "asyncReset";
    softPulse();
    pushExp(4, 3'b110, 1'b0, 1'b0, 2'd0);
    pushExp(6, 3'b110, 1'b0, 1'b0, 2'd0);
    runEdges(6);
    drain();
    #1;
    iReset = 1'b1;
    #1;
    checkVal("asyncReset immediate stageReset", 32'(bus.oStageReset), 32'h7);
    checkVal("asyncReset immediate allReady",   32'(bus.oAllReady),   32'h0);
    @(negedge iClock);
    iReset  = 1'b0;
    edgeCnt = 0;
    scen = "afterAsyncReset";
    pushRelease();
    runEdges(16);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
